cc_hit_miss_dispatch: RTL and testbench
=======================================

# cc_hit_miss_dispatch

Dispatch stage between the cache tag-compare pipeline and the data reorder unit. Each looked-up request gets exactly one entry in the hit-flag FIFO, written in acceptance order. A hit also writes its cache line and word offset into the hit-data FIFO. A miss issues a critical-word-first WRAP burst on the AXI AR channel to memory, with a bounded number of misses in flight.

## Interface
- MAX_OUTSTANDING, 4: maximum misses accepted but not yet completed (mem_r_done_i); range 1..15
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  tag-compare result valid
- req_ready_o  out  1  request accepted when valid & ready
- req_hit_i  in  1  1 = hit, 0 = miss
- req_addr_i  in  32  byte address of requested word
- req_line_i  in  512  cache line data (meaningful on hit only)
- hit_flag_fifo_afull_i  in  1  hit-flag FIFO almost full
- hit_flag_fifo_wren_o  out  1  hit-flag FIFO write strobe
- hit_flag_fifo_wdata_o  out  1  1 = hit, 0 = miss
- hit_data_fifo_afull_i  in  1  hit-data FIFO almost full
- hit_data_fifo_wren_o  out  1  hit-data FIFO write strobe
- hit_data_fifo_wdata_o  out  518  [517:512] = req_addr_i[5:0], [511:0] = req_line_i
- mem_arvalid_o  out  1  AR valid
- mem_arready_i  in  1  AR ready
- mem_araddr_o  out  32  {req_addr_i[31:3], 3'b000}
- mem_arlen_o  out  4  constant 4'd7 (8 beats)
- mem_arsize_o  out  3  constant 3'd3 (8 bytes)
- mem_arburst_o  out  2  constant 2'b10 (WRAP)
- mem_r_done_i  in  1  pulse: last R beat of a miss burst handshaken
- outstanding_o  out  4  current in-flight miss count

## Operation
- Accept condition, computed combinationally from registered state and FIFO flags only; no path from mem_arready_i:
  - hit: !hit_flag_fifo_afull_i & !hit_data_fifo_afull_i
  - miss: !hit_flag_fifo_afull_i & !mem_arvalid_o & (outstanding < MAX_OUTSTANDING)
  - req_ready_o = the condition selected by req_hit_i.
- On accept, the block registers the write:
  - hit_flag_fifo_wren_o = 1 next cycle, with wdata = req_hit_i.
  - If hit: hit_data_fifo_wren_o = 1 next cycle, with wdata = {addr[5:0], line}.
  - Both strobes deassert the following cycle unless another accept occurred.
- AR slot is a single-entry register:
  - A miss accept loads mem_araddr_o and sets mem_arvalid_o next cycle.
  - mem_arvalid_o and mem_araddr_o stay stable until the cycle mem_arready_i = 1, then mem_arvalid_o clears.
- AR issue state machine:
  - IDLE (arvalid = 0) -> WAIT on miss accept.
  - WAIT -> IDLE on mem_arready_i.
  - Misses are never accepted in WAIT.
- Outstanding counter:
  - +1 on miss accept; -1 on mem_r_done_i; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
  - mem_r_done_i at count 0 is ignored; the counter stays at 0 and does not underflow.
- Ordering: flag-FIFO order = acceptance order = AR issue order for misses = data-FIFO order for hits. The reorder unit relies on this.
- Hits are accepted while a miss AR is pending or misses are outstanding; hits are not blocked behind misses.

## Timing
- Reset: req_ready_o follows the accept condition (1 for a hit once the FIFO flags are clear). All of the following reset to 0:
  - hit_flag_fifo_wren_o, hit_data_fifo_wren_o, mem_arvalid_o
  - mem_araddr_o, hit_data_fifo_wdata_o, hit_flag_fifo_wdata_o
  - outstanding_o
- mem_arlen_o, mem_arsize_o and mem_arburst_o are constant at all times.
- Latency:
  - Accept in cycle N -> FIFO write strobes in cycle N+1.
  - Miss accept in cycle N -> mem_arvalid_o in cycle N+1; earliest AR handshake is N+1.
- Throughput:
  - Hits: 1 per cycle.
  - Misses: at most 1 per 2 cycles (AR slot must be empty at accept).
- Almost-full flags are sampled at accept time. Upstream FIFO thresholds must reserve 1 entry for the in-flight registered write. Writes are never dropped.
- Synchronous reset mid-operation:
  - Clears the pending AR, the write strobes and the counter the next cycle.
  - Any un-handshaken AR is abandoned; no partial state is retained.

## Test plan
- Single hit, addr 0x0000_1028, line pattern P, FIFOs empty -> cycle N+1: flag wren = 1 with wdata = 1; data wren = 1 with wdata[517:512] = 6'h28 and [511:0] = P; no AR.
- Single miss, addr 0x0000_2034, mem_arready_i = 1 -> N+1: arvalid = 1, araddr = 0x0000_2030, arlen = 7, arsize = 3, arburst = 2'b10; flag wdata = 0; outstanding = 1. Then mem_r_done_i pulse -> outstanding = 0.
- Miss with mem_arready_i held 0 for 5 cycles, then hit and second miss offered -> araddr/arvalid stable throughout; hit accepted; second miss stalled (req_ready_o = 0) until the cycle after the AR handshake.
- MAX_OUTSTANDING = 4, four misses with arready = 1 and no r_done -> fifth miss stalled. Then mem_r_done_i concurrent with a miss accept -> count stays 4. Stray r_done at count 0 -> count remains 0.
- hit_data_fifo_afull_i = 1: hit stalled while a miss is still accepted. hit_flag_fifo_afull_i = 1: both stalled. Flag write order matches acceptance order across a 6-request mixed stream.
- Synchronous reset asserted while arvalid = 1 and outstanding = 3 -> next cycle all outputs return to reset values; the first post-reset hit completes normally.

Source files
------------

// File: rtl/cc_hit_miss_dispatch.sv
// cc_hit_miss_dispatch
// Dispatch stage between the tag-compare pipeline and the data reorder unit.
// Every accepted request produces one hit-flag FIFO write. Hits also write
// {word offset, line} into the hit-data FIFO. Misses load a single-entry AR
// slot that issues a critical-word-first WRAP burst. A counter bounds the
// number of misses in flight.
module cc_hit_miss_dispatch #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_hit_i,
    input  logic [31:0]  req_addr_i,
    input  logic [511:0] req_line_i,
    input  logic         hit_flag_fifo_afull_i,
    output logic         hit_flag_fifo_wren_o,
    output logic         hit_flag_fifo_wdata_o,
    input  logic         hit_data_fifo_afull_i,
    output logic         hit_data_fifo_wren_o,
    output logic [517:0] hit_data_fifo_wdata_o,
    output logic         mem_arvalid_o,
    input  logic         mem_arready_i,
    output logic [31:0]  mem_araddr_o,
    output logic [3:0]   mem_arlen_o,
    output logic [2:0]   mem_arsize_o,
    output logic [1:0]   mem_arburst_o,
    input  logic         mem_r_done_i,
    output logic [3:0]   outstanding_o
);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    ar_state_e  ar_state;
    ar_state_e  ar_state_next;
    logic [3:0] outstanding;
    logic       hit_ok;
    logic       miss_ok;
    logic       accept;
    logic       hit_accept;
    logic       miss_accept;
    logic       done_dec;

    // Accept decision from registered state and FIFO flags only, so there is
    // no combinational path from mem_arready_i to req_ready_o.
    always_comb begin
        hit_ok      = !hit_flag_fifo_afull_i && !hit_data_fifo_afull_i;
        miss_ok     = !hit_flag_fifo_afull_i && (ar_state == AR_IDLE)
                      && (outstanding < MAX_CNT);
        req_ready_o = req_hit_i ? hit_ok : miss_ok;
        accept      = req_valid_i && req_ready_o;
        hit_accept  = accept && req_hit_i;
        miss_accept = accept && !req_hit_i;
        done_dec    = mem_r_done_i && (outstanding != 4'd0);
    end

    // AR slot state register; a reset abandons any un-handshaken request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_state <= AR_IDLE;
        end else begin
            ar_state <= ar_state_next;
        end
    end

    // AR slot fills on a miss accept and empties on the AR handshake.
    always_comb begin
        ar_state_next = ar_state;
        case (ar_state)
            AR_IDLE: if (miss_accept)   ar_state_next = AR_WAIT;
            AR_WAIT: if (mem_arready_i) ar_state_next = AR_IDLE;
            default: ar_state_next = AR_IDLE;
        endcase
    end

    // Registered FIFO writes: one flag per accept, data only for hits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_flag_fifo_wren_o  <= 1'b0;
            hit_flag_fifo_wdata_o <= 1'b0;
            hit_data_fifo_wren_o  <= 1'b0;
            hit_data_fifo_wdata_o <= '0;
        end else begin
            hit_flag_fifo_wren_o <= accept;
            hit_data_fifo_wren_o <= hit_accept;
            if (accept) begin
                hit_flag_fifo_wdata_o <= req_hit_i;
            end
            if (hit_accept) begin
                hit_data_fifo_wdata_o <= {req_addr_i[5:0], req_line_i};
            end
        end
    end

    // AR address is captured on a miss accept and held until the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_araddr_o <= '0;
        end else if (miss_accept) begin
            mem_araddr_o <= {req_addr_i[31:3], 3'b000};
        end
    end

    // In-flight miss count; simultaneous accept and completion cancel out,
    // and a completion at zero is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= 4'd0;
        end else begin
            case ({miss_accept, done_dec})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign mem_arvalid_o = (ar_state == AR_WAIT);
    assign mem_arlen_o   = 4'd7;
    assign mem_arsize_o  = 3'd3;
    assign mem_arburst_o = 2'b10;
    assign outstanding_o = outstanding;

endmodule

// File: tb/tb_cc_hit_miss_dispatch.sv
// tb_cc_hit_miss_dispatch
// Directed scenarios with literal expectations followed by a randomized run.
// A behavioural model predicts every output each cycle, and queues track the
// acceptance order seen on the flag FIFO and the AR channel.
module tb_cc_hit_miss_dispatch;

    localparam int MAX_OUT = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_hit_i;
    logic [31:0]  req_addr_i;
    logic [511:0] req_line_i;
    logic         hit_flag_fifo_afull_i;
    logic         hit_flag_fifo_wren_o;
    logic         hit_flag_fifo_wdata_o;
    logic         hit_data_fifo_afull_i;
    logic         hit_data_fifo_wren_o;
    logic [517:0] hit_data_fifo_wdata_o;
    logic         mem_arvalid_o;
    logic         mem_arready_i;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic [2:0]   mem_arsize_o;
    logic [1:0]   mem_arburst_o;
    logic         mem_r_done_i;
    logic [3:0]   outstanding_o;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking_on = 0;

    cc_hit_miss_dispatch #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_hit_i             (req_hit_i),
        .req_addr_i            (req_addr_i),
        .req_line_i            (req_line_i),
        .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
        .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
        .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
        .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
        .mem_arvalid_o         (mem_arvalid_o),
        .mem_arready_i         (mem_arready_i),
        .mem_araddr_o          (mem_araddr_o),
        .mem_arlen_o           (mem_arlen_o),
        .mem_arsize_o          (mem_arsize_o),
        .mem_arburst_o         (mem_arburst_o),
        .mem_r_done_i          (mem_r_done_i),
        .outstanding_o         (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit           m_flag_wren;
    bit           m_flag_wdata;
    bit           m_data_wren;
    logic [517:0] m_data_wdata;
    bit           m_arvalid;
    logic [31:0]  m_araddr;
    int           m_count;
    bit           q_flag[$];
    logic [31:0]  q_ar[$];
    logic         m_acc;

    function automatic bit model_ready(input logic hit, input logic ffa, input logic dfa,
                                       input bit arv, input int cnt);
        if (hit) return !ffa && !dfa;
        return !ffa && !arv && (cnt < MAX_OUT);
    endfunction

    assign m_acc = req_valid_i && model_ready(req_hit_i, hit_flag_fifo_afull_i,
                                              hit_data_fifo_afull_i, m_arvalid, m_count);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWide(input string name, input logic [517:0] act, input logic [517:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: what the registered outputs must be next cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            m_flag_wren  <= 0;
            m_flag_wdata <= 0;
            m_data_wren  <= 0;
            m_data_wdata <= '0;
            m_arvalid    <= 0;
            m_araddr     <= '0;
            m_count      <= 0;
            q_flag.delete();
            q_ar.delete();
        end else begin
            m_flag_wren <= m_acc;
            m_data_wren <= m_acc && req_hit_i;
            if (m_acc) begin
                m_flag_wdata <= req_hit_i;
                q_flag.push_back(req_hit_i);
            end
            if (m_acc && req_hit_i) m_data_wdata <= {req_addr_i[5:0], req_line_i};
            if (m_acc && !req_hit_i) begin
                m_arvalid <= 1;
                m_araddr  <= {req_addr_i[31:3], 3'b000};
                q_ar.push_back({req_addr_i[31:3], 3'b000});
            end else if (mem_arready_i) begin
                m_arvalid <= 0;
            end
            m_count <= m_count + ((m_acc && !req_hit_i) ? 1 : 0)
                               - ((mem_r_done_i && m_count > 0) ? 1 : 0);
        end
    end

    // Compare DUT against the model every cycle, mid-period
    always @(negedge clk) begin
        if (checking_on) begin
            checkOutput("req_ready", 64'(req_ready_o),
                        64'(model_ready(req_hit_i, hit_flag_fifo_afull_i,
                                        hit_data_fifo_afull_i, m_arvalid, m_count)));
            checkOutput("flag_wren", 64'(hit_flag_fifo_wren_o), 64'(m_flag_wren));
            if (m_flag_wren) checkOutput("flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'(m_flag_wdata));
            checkOutput("data_wren", 64'(hit_data_fifo_wren_o), 64'(m_data_wren));
            if (m_data_wren) checkWide("data_wdata", hit_data_fifo_wdata_o, m_data_wdata);
            checkOutput("arvalid", 64'(mem_arvalid_o), 64'(m_arvalid));
            if (m_arvalid) checkOutput("araddr", 64'(mem_araddr_o), 64'(m_araddr));
            checkOutput("outstanding", 64'(outstanding_o), 64'(m_count));
            checkOutput("arlen", 64'(mem_arlen_o), 64'd7);
            checkOutput("arsize", 64'(mem_arsize_o), 64'd3);
            checkOutput("arburst", 64'(mem_arburst_o), 64'd2);
            if (hit_flag_fifo_wren_o) begin
                if (q_flag.size() == 0) checkOutput("flag_order_empty", 64'd1, 64'd0);
                else checkOutput("flag_order", 64'(hit_flag_fifo_wdata_o), 64'(q_flag.pop_front()));
            end
            if (mem_arvalid_o && mem_arready_i) begin
                if (q_ar.size() == 0) checkOutput("ar_order_empty", 64'd1, 64'd0);
                else checkOutput("ar_order", 64'(mem_araddr_o), 64'(q_ar.pop_front()));
            end
        end
    end

    // Drive one cycle of inputs just after the edge, then wait to mid-period
    task automatic applyStimulus(input logic v, input logic hit, input logic [31:0] addr,
                                 input logic [511:0] line, input logic ffa, input logic dfa,
                                 input logic ardy, input logic rdone);
        @(posedge clk);
        #1;
        req_valid_i           = v;
        req_hit_i             = hit;
        req_addr_i            = addr;
        req_line_i            = line;
        hit_flag_fifo_afull_i = ffa;
        hit_data_fifo_afull_i = dfa;
        mem_arready_i         = ardy;
        mem_r_done_i          = rdone;
        @(negedge clk);
    endtask

    task automatic idle(input logic ardy, input logic rdone);
        applyStimulus(1'b0, 1'b1, 32'h0, '0, 1'b0, 1'b0, ardy, rdone);
    endtask

    // Offer a request until accepted, with a bounded number of tries
    task automatic offerUntilAccepted(input logic hit, input logic [31:0] addr,
                                      input logic [511:0] line);
        bit done = 0;
        for (int t = 0; t < 10 && !done; t++) begin
            applyStimulus(1'b1, hit, addr, line, 1'b0, 1'b0, 1'b1, 1'b0);
            done = req_ready_o;
        end
        if (!done) checkOutput("stream_accept_timeout", 64'd0, 64'd1);
    endtask

    logic [511:0] pat;
    logic [511:0] rline;

    initial begin
        rst_n = 0;
        req_valid_i = 0; req_hit_i = 1; req_addr_i = '0; req_line_i = '0;
        hit_flag_fifo_afull_i = 0; hit_data_fifo_afull_i = 0;
        mem_arready_i = 0; mem_r_done_i = 0;
        pat = {16{32'hDEAD_BEEF}};

        // Reset state
        @(posedge clk);
        checking_on = 1;
        idle(1'b0, 1'b0);
        checkOutput("rst_ready", 64'(req_ready_o), 64'd1);
        checkOutput("rst_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd0);
        checkOutput("rst_arvalid", 64'(mem_arvalid_o), 64'd0);
        checkOutput("rst_outstanding", 64'(outstanding_o), 64'd0);
        checkWide("rst_data_wdata", hit_data_fifo_wdata_o, '0);
        rst_n = 1;

        // Single hit
        applyStimulus(1'b1, 1'b1, 32'h0000_1028, pat, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_ready", 64'(req_ready_o), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t1_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd1);
        checkOutput("t1_flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'd1);
        checkOutput("t1_data_wren", 64'(hit_data_fifo_wren_o), 64'd1);
        checkOutput("t1_offset", 64'(hit_data_fifo_wdata_o[517:512]), 64'h28);
        checkWide("t1_line", 518'(hit_data_fifo_wdata_o[511:0]), 518'(pat));
        checkOutput("t1_no_ar", 64'(mem_arvalid_o), 64'd0);
        idle(1'b0, 1'b0);
        checkOutput("t1_flag_wren_off", 64'(hit_flag_fifo_wren_o), 64'd0);

        // Single miss, AR accepted immediately, then completion
        applyStimulus(1'b1, 1'b0, 32'h0000_2034, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_ready", 64'(req_ready_o), 64'd1);
        idle(1'b1, 1'b0);
        checkOutput("t2_arvalid", 64'(mem_arvalid_o), 64'd1);
        checkOutput("t2_araddr", 64'(mem_araddr_o), 64'h0000_2030);
        checkOutput("t2_arlen", 64'(mem_arlen_o), 64'd7);
        checkOutput("t2_flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'd0);
        checkOutput("t2_data_wren", 64'(hit_data_fifo_wren_o), 64'd0);
        checkOutput("t2_outstanding", 64'(outstanding_o), 64'd1);
        idle(1'b0, 1'b0);
        checkOutput("t2_arvalid_clr", 64'(mem_arvalid_o), 64'd0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t2_outstanding_done", 64'(outstanding_o), 64'd0);

        // Miss with AR stalled; hit passes, second miss waits for the handshake
        applyStimulus(1'b1, 1'b0, 32'h0000_3008, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                applyStimulus(1'b1, 1'b1, 32'h0000_3100, pat, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput("t3_hit_ready", 64'(req_ready_o), 64'd1);
            end else if (i >= 3) begin
                applyStimulus(1'b1, 1'b0, 32'h0000_4010, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput("t3_miss_stall", 64'(req_ready_o), 64'd0);
            end else begin
                idle(1'b0, 1'b0);
            end
            checkOutput("t3_arvalid_hold", 64'(mem_arvalid_o), 64'd1);
            checkOutput("t3_araddr_hold", 64'(mem_araddr_o), 64'h0000_3008);
        end
        applyStimulus(1'b1, 1'b0, 32'h0000_4010, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_stall_at_hs", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_4010, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_miss2_ready", 64'(req_ready_o), 64'd1);
        idle(1'b1, 1'b0);
        checkOutput("t3_araddr2", 64'(mem_araddr_o), 64'h0000_4010);
        checkOutput("t3_outstanding", 64'(outstanding_o), 64'd2);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t3_drained", 64'(outstanding_o), 64'd0);

        // Fill to MAX_OUTSTANDING, then concurrent done/accept and stray done
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b0, 32'h0000_5000 + 32'(i * 64), '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_6000, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_count_full", 64'(outstanding_o), 64'd4);
        checkOutput("t4_fifth_stall", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_6000, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_stall_with_done", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_6000, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_count_after_done", 64'(outstanding_o), 64'd3);
        checkOutput("t4_accept_with_done", 64'(req_ready_o), 64'd1);
        idle(1'b1, 1'b1);
        checkOutput("t4_count_unchanged", 64'(outstanding_o), 64'd3);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t4_stray_done", 64'(outstanding_o), 64'd0);

        // Almost-full flags
        applyStimulus(1'b1, 1'b1, 32'h0000_7000, pat, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_hit_dfull", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_7040, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_miss_dfull", 64'(req_ready_o), 64'd1);
        applyStimulus(1'b1, 1'b1, 32'h0000_7080, pat, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_hit_ffull", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_70C0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_miss_ffull", 64'(req_ready_o), 64'd0);
        idle(1'b0, 1'b1);

        // Mixed six-request stream; order is checked by the compare process
        offerUntilAccepted(1'b1, 32'h0000_8004, pat);
        offerUntilAccepted(1'b0, 32'h0000_8100, '0);
        offerUntilAccepted(1'b1, 32'h0000_8208, ~pat);
        offerUntilAccepted(1'b1, 32'h0000_830C, pat);
        offerUntilAccepted(1'b0, 32'h0000_8410, '0);
        offerUntilAccepted(1'b1, 32'h0000_8514, ~pat);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("t5_drained", 64'(outstanding_o), 64'd0);

        // Reset with a pending AR and three misses outstanding
        applyStimulus(1'b1, 1'b0, 32'h0000_9000, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_9040, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_9080, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("t6_pre_arvalid", 64'(mem_arvalid_o), 64'd1);
        checkOutput("t6_pre_count", 64'(outstanding_o), 64'd3);
        rst_n = 0;
        idle(1'b0, 1'b0);
        checkOutput("t6_arvalid", 64'(mem_arvalid_o), 64'd0);
        checkOutput("t6_araddr", 64'(mem_araddr_o), 64'd0);
        checkOutput("t6_count", 64'(outstanding_o), 64'd0);
        checkOutput("t6_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd0);
        rst_n = 1;
        applyStimulus(1'b1, 1'b1, 32'h0000_A004, pat, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("t6_post_flag", 64'(hit_flag_fifo_wren_o), 64'd1);
        checkOutput("t6_post_data", 64'(hit_data_fifo_wren_o), 64'd1);
        checkOutput("t6_post_offset", 64'(hit_data_fifo_wdata_o[517:512]), 64'h04);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int w = 0; w < 16; w++) rline[w*32 +: 32] = $urandom();
            rst_n = ($urandom_range(0, 199) != 0);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom(), rline,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
        end
        rst_n = 1;
        idle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
